// File: rtl/axil_rd_chan_q.sv
// AXI4-Lite read-channel slave: credit-throttled AR, fixed-latency register-block
// issue pipe and an in-order response queue. Optional macro: AXIL_RD_RANGE_CHK_EN.

module axil_rd_chan_q_chk (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic full
);
    // a push into a full queue means the credit accounting is broken
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule

module axil_rd_chan_q #(
    parameter int DW    = 32,
    parameter int AW    = 8,
    parameter int DEPTH = 4,
    parameter int RDLAT = 1
) (
    input  logic          iCLK,
    input  logic          iRSTN,
    input  logic [31:0]   iARADDR,
    input  logic          iARVALID,
    output logic          oARREADY,
    output logic [DW-1:0] oRDATA,
    output logic [1:0]    oRRESP,
    output logic          oRVALID,
    input  logic          iRREADY,
    output logic [AW-1:0] oPRADR,
    output logic          oPREN,
    input  logic [DW-1:0] iPRDAT,
    input  logic          iPERR
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_nxt_s;
    logic            ar_acc_s;
    logic            r_hs_s;
    logic            oor_s;
    logic [RDLAT:0]  st_v_r;
    logic [RDLAT:0]  st_err_r;
    logic [PW:0]     wptr_r;
    logic [PW:0]     rptr_r;
    logic [DW+1:0]   mem_r [DEPTH];
    logic            push_s;
    logic            empty_s;
    logic            full_s;
    logic [DW+1:0]   push_word_s;
    logic [DW+1:0]   head_s;

`ifdef AXIL_RD_RANGE_CHK_EN
    assign oor_s = |iARADDR[31:AW];
`else
    logic addr_hi_unused_s;
    assign addr_hi_unused_s = ^iARADDR[31:AW];
    assign oor_s = 1'b0;
`endif

    assign ar_acc_s = iARVALID & oARREADY;
    assign r_hs_s   = oRVALID & iRREADY;

    // credits: one per read between AR accept and R handshake
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (ar_acc_s && !r_hs_s) begin
            cnt_nxt_s = cnt_r + CW'(1);
        end else if (!ar_acc_s && r_hs_s) begin
            cnt_nxt_s = cnt_r - CW'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // credit counter and registered address-ready
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            cnt_r    <= {CW{1'b0}};
            oARREADY <= 1'b0;
        end else begin
            cnt_r    <= cnt_nxt_s;
            oARREADY <= (cnt_nxt_s < CW'(DEPTH));
        end
    end

    // issue stage strobe to the register block
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            oPREN  <= 1'b0;
            oPRADR <= {AW{1'b0}};
        end else begin
            oPREN  <= ar_acc_s & ~oor_s;
            oPRADR <= (ar_acc_s && !oor_s) ? iARADDR[AW-1:0] : {AW{1'b0}};
        end
    end

    // stage 0 is the issue cycle; stage RDLAT is the cycle the read data is sampled
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            st_v_r   <= {(RDLAT+1){1'b0}};
            st_err_r <= {(RDLAT+1){1'b0}};
        end else begin
            st_v_r[0]   <= ar_acc_s;
            st_err_r[0] <= ar_acc_s & oor_s;
            for (int i = 1; i <= RDLAT; i++) begin
                st_v_r[i]   <= st_v_r[i-1];
                st_err_r[i] <= st_err_r[i-1];
            end
        end
    end

    assign push_s      = st_v_r[RDLAT];
    assign push_word_s = st_err_r[RDLAT] ? {{DW{1'b0}}, RESP_SLVERR}
                                         : {iPRDAT, (iPERR ? RESP_SLVERR : RESP_OKAY)};
    assign empty_s     = (wptr_r == rptr_r);
    assign full_s      = (wptr_r[PW] != rptr_r[PW]) && (wptr_r[PW-1:0] == rptr_r[PW-1:0]);

    // response queue storage
    always_ff @(posedge iCLK) begin
        if (push_s) begin
            mem_r[wptr_r[PW-1:0]] <= push_word_s;
        end
    end

    // queue pointers; the extra MSB distinguishes full from empty
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            wptr_r <= {(PW+1){1'b0}};
            rptr_r <= {(PW+1){1'b0}};
        end else begin
            wptr_r <= wptr_r + (PW+1)'(push_s);
            rptr_r <= rptr_r + (PW+1)'(r_hs_s);
        end
    end

    assign head_s  = mem_r[rptr_r[PW-1:0]];
    assign oRVALID = ~empty_s;
    assign oRDATA  = empty_s ? {DW{1'b0}} : head_s[DW+1:2];
    assign oRRESP  = empty_s ? RESP_OKAY : head_s[1:0];

    axil_rd_chan_q_chk u_chk (
        .clk   (iCLK),
        .rst_n (iRSTN),
        .push  (push_s),
        .full  (full_s)
    );

endmodule

// File: tb/tb_axil_rd_chan_q.sv
// Randomised scoreboard bench for axil_rd_chan_q: a register-block model supplies
// tabled data; a monitor checks every output cycle against a transaction-level model.

module tb_axil_rd_chan_q;
    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int RDLAT = 1;
    localparam int NTBL  = 1024;

    logic          iCLK;
    logic          iRSTN;
    logic [31:0]   iARADDR;
    logic          iARVALID;
    logic          oARREADY;
    logic [DW-1:0] oRDATA;
    logic [1:0]    oRRESP;
    logic          oRVALID;
    logic          iRREADY;
    logic [AW-1:0] oPRADR;
    logic          oPREN;
    logic [DW-1:0] iPRDAT;
    logic          iPERR;

    axil_rd_chan_q #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .RDLAT(RDLAT)) dut (
        .iCLK(iCLK), .iRSTN(iRSTN), .iARADDR(iARADDR), .iARVALID(iARVALID),
        .oARREADY(oARREADY), .oRDATA(oRDATA), .oRRESP(oRRESP), .oRVALID(oRVALID),
        .iRREADY(iRREADY), .oPRADR(oPRADR), .oPREN(oPREN), .iPRDAT(iPRDAT), .iPERR(iPERR)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    logic [DW-1:0] tbl_data [0:NTBL-1];
    bit            tbl_err  [0:NTBL-1];

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        int            acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   final_chk = 1'b0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endfunction

    // register-block model: the k-th read strobe since reset returns table entry k, RDLAT cycles later
    int rb_idx = 0;
    int hist_i [0:RDLAT];
    bit hist_v [0:RDLAT];
    always @(posedge iCLK) begin
        #1;
        if (!iRSTN) begin
            rb_idx = 0;
            for (int i = 0; i <= RDLAT; i++) hist_v[i] = 1'b0;
        end else begin
            for (int i = RDLAT; i > 0; i--) begin
                hist_v[i] = hist_v[i-1];
                hist_i[i] = hist_i[i-1];
            end
            hist_v[0] = oPREN;
            hist_i[0] = rb_idx;
            if (oPREN) rb_idx++;
        end
        if (hist_v[RDLAT]) begin
            iPRDAT = tbl_data[hist_i[RDLAT]];
            iPERR  = tbl_err[hist_i[RDLAT]];
        end else begin
            iPRDAT = $urandom;
            iPERR  = 1'($urandom_range(0, 1));
        end
    end

    // monitor: transaction-level expectations, checked every cycle at the falling edge
    int            cyc = 0;
    int            last_pop = 0;
    int            outst = 0;
    int            ir_idx = 0;
    bit            prev_acc = 1'b0;
    bit            prev_inr = 1'b0;
    bit            prev_rst_ok = 1'b0;
    bit            fin_done = 1'b0;
    logic [AW-1:0] prev_adr = '0;
    always @(negedge iCLK) begin
        bit   acc, hs, oor, exp_v;
        int   avail;
        exp_t e;
        cyc++;
        if (!iRSTN) begin
            chk("rst_arready", 64'(oARREADY), 64'(0));
            chk("rst_rvalid",  64'(oRVALID),  64'(0));
            chk("rst_rdata",   64'(oRDATA),   64'(0));
            chk("rst_rresp",   64'(oRRESP),   64'(0));
            chk("rst_pren",    64'(oPREN),    64'(0));
            chk("rst_pradr",   64'(oPRADR),   64'(0));
            sb.delete();
            outst = 0; ir_idx = 0; last_pop = 0;
            prev_acc = 1'b0; prev_inr = 1'b0; prev_rst_ok = 1'b0;
        end else begin
            chk("arready", 64'(oARREADY), 64'(prev_rst_ok && (outst < DEPTH)));
            chk("pren",    64'(oPREN),    64'(prev_acc && prev_inr));
            chk("pradr",   64'(oPRADR),   64'((prev_acc && prev_inr) ? prev_adr : '0));
            exp_v = 1'b0;
            if (sb.size() > 0) begin
                avail = sb[0].acc_cyc + 2 + RDLAT;
                if (last_pop + 1 > avail) avail = last_pop + 1;
                exp_v = (cyc >= avail);
            end
            chk("rvalid", 64'(oRVALID), 64'(exp_v));
            if (oRVALID && sb.size() > 0) begin
                chk("rdata", 64'(oRDATA), 64'(sb[0].data));
                chk("rresp", 64'(oRRESP), 64'(sb[0].resp));
            end else if (!oRVALID) begin
                chk("rdata_idle", 64'({oRDATA, oRRESP}), 64'(0));
            end
            hs = oRVALID && iRREADY;
            if (hs && sb.size() > 0) begin
                void'(sb.pop_front());
                last_pop = cyc;
            end
            acc = iARVALID && oARREADY;
            oor = 1'b0;
`ifdef AXIL_RD_RANGE_CHK_EN
            oor = (iARADDR[31:AW] != '0);
`endif
            if (acc) begin
                e.acc_cyc = cyc;
                if (oor) begin
                    e.data = '0;
                    e.resp = 2'b10;
                end else begin
                    e.data = tbl_data[ir_idx];
                    e.resp = tbl_err[ir_idx] ? 2'b10 : 2'b00;
                    ir_idx++;
                end
                sb.push_back(e);
            end
            outst    = outst + int'(acc) - int'(hs);
            prev_acc = acc;
            prev_inr = !oor;
            prev_adr = iARADDR[AW-1:0];
            prev_rst_ok = 1'b1;
        end
        if (final_chk && !fin_done) begin
            chk("drain", 64'(sb.size()), 64'(0));
            fin_done = 1'b1;
        end
    end

    task automatic ar_issue(input logic [31:0] a);
        bit got;
        got = 1'b0;
        iARVALID = 1'b1;
        iARADDR  = a;
        for (int k = 0; k < 500 && !got; k++) begin
            @(negedge iCLK);
            got = oARREADY;
            @(posedge iCLK);
            #1;
        end
        if (!got) begin
            $display("FAIL ar_timeout: address %0h never accepted", a);
            $fatal(1, "AR handshake timeout");
        end
    endtask

    task automatic ar_idle();
        iARVALID = 1'b0;
        iARADDR  = $urandom;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] hi;
        hi = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'h0;
        return {hi[23:0], 8'($urandom_range(0, 63) * 4)};
    endfunction

    bit stim_done;
    initial begin
        iRSTN = 1'b1; iARVALID = 1'b0; iARADDR = 32'h0; iRREADY = 1'b0;
        iPRDAT = '0; iPERR = 1'b0;
        for (int i = 0; i < NTBL; i++) begin
            tbl_data[i] = $urandom;
            tbl_err[i]  = ($urandom_range(0, 3) == 0);
        end
        tbl_data[0] = 32'hA5A5_0001; tbl_err[0] = 1'b0;
        tbl_err[1] = 1'b0; tbl_err[2] = 1'b1; tbl_err[3] = 1'b0;
        #1 iRSTN = 1'b0;
        cycles(4);
        iRSTN = 1'b1;
        cycles(2);

        // single read
        iRREADY = 1'b1;
        ar_issue(32'h0000_0004);
        ar_idle();
        cycles(6);

        // back-to-back reads, second of the first three returns an error
        for (int i = 0; i < 8; i++) ar_issue(32'(i * 4 + 8));
        ar_idle();
        cycles(8);

        // stall: six reads against a blocked R channel
        iRREADY = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) ar_issue(32'(8'($urandom_range(0, 63) * 4)));
                ar_idle();
            end
            begin
                cycles(14);
                iRREADY = 1'b1;
            end
        join
        cycles(10);

        // upper address bits set
        ar_issue(32'h0000_0104);
        ar_idle();
        cycles(6);

        // random traffic with random back-pressure
        stim_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    ar_issue(rand_addr());
                    if ($urandom_range(0, 2) == 0) begin
                        ar_idle();
                        cycles($urandom_range(1, 3));
                    end
                end
                ar_idle();
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    @(posedge iCLK);
                    #1;
                    iRREADY = ($urandom_range(0, 2) != 0);
                end
            end
        join
        iRREADY = 1'b1;
        cycles(12);

        // reset with reads queued
        iRREADY = 1'b0;
        for (int i = 0; i < 3; i++) ar_issue(32'(i * 4 + 32));
        ar_idle();
        cycles(6);
        iRSTN = 1'b0;
        cycles(3);
        iRSTN = 1'b1;
        cycles(2);
        iRREADY = 1'b1;
        ar_issue(32'h0000_0010);
        ar_idle();
        cycles(8);

        for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge iCLK);
        #1;
        final_chk = 1'b1;
        @(negedge iCLK);
        @(negedge iCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
